// File: rtl/aes_if_pkg.sv
`default_nettype none
// ============================================================
// Module   : aes_if_pkg
// Purpose  : AES register map, handshake states, byte-merge helper
// Revision : 1.0
// ============================================================
package aes_if_pkg;

  localparam int REG_ADDR_W = 4;
  typedef logic [REG_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_KEY0  = 4'd0;
  localparam reg_idx_t REG_ENC0  = 4'd4;
  localparam reg_idx_t REG_DEC0  = 4'd8;
  localparam reg_idx_t REG_CNT   = 4'd12;
  localparam reg_idx_t REG_START = 4'd14;
  localparam reg_idx_t REG_DONE  = 4'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } aes_if_state_t;

  function automatic logic [31:0] be_merge(input logic [31:0] old_w,
                                           input logic [31:0] new_w,
                                           input logic [3:0]  be);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/avalon_aes_interface_if.sv
`default_nettype none
// ============================================================
// Module   : avalon_aes_interface_if
// Purpose  : Avalon-MM slave bus plus AES core conduit
// Revision : 1.0
// ============================================================
interface avalon_aes_interface_if;

  logic         AVL_READ;
  logic         AVL_WRITE;
  logic         AVL_CS;
  logic [3:0]   AVL_BYTE_EN;
  logic [3:0]   AVL_ADDR;
  logic [31:0]  AVL_WRITEDATA;
  logic [31:0]  AVL_READDATA;
  logic [31:0]  EXPORT_DATA;
  logic         AES_START;
  logic [127:0] AES_KEY;
  logic [127:0] AES_MSG_ENC;
  logic         AES_DONE;
  logic [127:0] AES_MSG_DEC;

  modport master (
    output AVL_READ, AVL_WRITE, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
    output AES_DONE, AES_MSG_DEC,
    input  AVL_READDATA, EXPORT_DATA, AES_START, AES_KEY, AES_MSG_ENC
  );

  modport slave (
    input  AVL_READ, AVL_WRITE, AVL_CS, AVL_BYTE_EN, AVL_ADDR, AVL_WRITEDATA,
    input  AES_DONE, AES_MSG_DEC,
    output AVL_READDATA, EXPORT_DATA, AES_START, AES_KEY, AES_MSG_ENC
  );

endinterface
`default_nettype wire

// File: rtl/aes_if_regfile.sv
`default_nettype none
// ============================================================
// Module   : aes_if_regfile
// Purpose  : 16x32 register storage, byte-enable writes, DEC capture
// Revision : 1.0
// ============================================================
module aes_if_regfile
  import aes_if_pkg::*;
#(
  parameter int       NUM_REGS  = 16,
  parameter reg_idx_t START_IDX = REG_START,
  parameter reg_idx_t DONE_IDX  = REG_DONE
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         sw_we,
  input  wire reg_idx_t     sw_addr,
  input  wire logic [31:0]  sw_wdata,
  input  wire logic [3:0]   sw_be,
  input  wire logic         cap_en,
  input  wire logic [127:0] cap_data,
  input  wire logic         done_val,
  input  wire reg_idx_t     rd_addr,
  output logic [31:0]       rd_data,
  output logic [127:0]      key,
  output logic [127:0]      msg_enc
);

  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];
  logic        sw_writable;

  // Only key, encrypted message and START are software-owned.
  assign sw_writable = (sw_addr < REG_DEC0) || (sw_addr == START_IDX);

  always_comb begin
    regs_d = regs_q;
    if (sw_we && sw_writable) begin
      regs_d[sw_addr] = be_merge(regs_q[sw_addr], sw_wdata, sw_be);
    end
    if (cap_en) begin
      regs_d[REG_DEC0]         = cap_data[127:96];
      regs_d[REG_DEC0 + 4'd1]  = cap_data[95:64];
      regs_d[REG_DEC0 + 4'd2]  = cap_data[63:32];
      regs_d[REG_DEC0 + 4'd3]  = cap_data[31:0];
    end
    regs_d[DONE_IDX] = {31'b0, done_val};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q <= '{default: '0};
    end else begin
      regs_q <= regs_d;
    end
  end

  assign rd_data = regs_q[rd_addr];
  assign key     = {regs_q[REG_KEY0], regs_q[REG_KEY0 + 4'd1],
                    regs_q[REG_KEY0 + 4'd2], regs_q[REG_KEY0 + 4'd3]};
  assign msg_enc = {regs_q[REG_ENC0], regs_q[REG_ENC0 + 4'd1],
                    regs_q[REG_ENC0 + 4'd2], regs_q[REG_ENC0 + 4'd3]};

endmodule
`default_nettype wire

// File: rtl/avalon_aes_interface.sv
`default_nettype none
// ============================================================
// Module   : avalon_aes_interface
// Purpose  : Avalon-MM register file and handshake for the AES core;
//            AES_CYCLE_COUNT_EN adds a RUN-cycle counter at reg 12.
// Revision : 1.0
// ============================================================
module avalon_aes_interface
  import aes_if_pkg::*;
#(
  parameter int       NUM_REGS  = 16,
  parameter reg_idx_t START_IDX = REG_START,
  parameter reg_idx_t DONE_IDX  = REG_DONE
) (
  input  wire logic              CLK,
  input  wire logic              RESET,
  avalon_aes_interface_if.slave  avl
);

  aes_if_state_t state_q, state_d;
  logic          sw_we;
  logic          start_wr;
  logic          start_set;
  logic          start_clr;
  logic          cap_en;
  logic [31:0]   rf_rd_data;
  logic [31:0]   rd_word;
  logic [127:0]  key;
  logic [127:0]  msg_enc;

  assign sw_we     = avl.AVL_CS && avl.AVL_WRITE;
  assign start_wr  = sw_we && (avl.AVL_ADDR == START_IDX) && avl.AVL_BYTE_EN[0];
  assign start_set = start_wr && avl.AVL_WRITEDATA[0];
  assign start_clr = start_wr && !avl.AVL_WRITEDATA[0];

  // A clear of START wins over a same-cycle completion, so an abort never captures.
  always_comb begin
    state_d = state_q;
    cap_en  = 1'b0;
    case (state_q)
      IDLE: if (start_set) state_d = RUN;
      RUN: begin
        if (start_clr) begin
          state_d = IDLE;
        end else if (avl.AES_DONE) begin
          cap_en  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: if (start_clr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  aes_if_regfile #(
    .NUM_REGS  (NUM_REGS),
    .START_IDX (START_IDX),
    .DONE_IDX  (DONE_IDX)
  ) u_regfile (
    .clk      (CLK),
    .rst      (RESET),
    .sw_we    (sw_we),
    .sw_addr  (avl.AVL_ADDR),
    .sw_wdata (avl.AVL_WRITEDATA),
    .sw_be    (avl.AVL_BYTE_EN),
    .cap_en   (cap_en),
    .cap_data (avl.AES_MSG_DEC),
    .done_val (state_d == DONE),
    .rd_addr  (avl.AVL_ADDR),
    .rd_data  (rf_rd_data),
    .key      (key),
    .msg_enc  (msg_enc)
  );

`ifdef AES_CYCLE_COUNT_EN
  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE && state_d == RUN) begin
      cnt_d = '0;
    end else if (state_q == RUN && state_d == RUN && cnt_q != '1) begin
      cnt_d = cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  always_comb begin
    rd_word = rf_rd_data;
`ifdef AES_CYCLE_COUNT_EN
    if (avl.AVL_ADDR == REG_CNT) rd_word = cnt_q;
`endif
  end

  assign avl.AVL_READDATA = (avl.AVL_CS && avl.AVL_READ) ? rd_word : 32'h0;
  assign avl.AES_START    = (state_q != IDLE);
  assign avl.AES_KEY      = key;
  assign avl.AES_MSG_ENC  = msg_enc;
  assign avl.EXPORT_DATA  = {key[127:112], key[15:0]};

endmodule
`default_nettype wire

// File: tb/tb_avalon_aes_interface.sv
`default_nettype none
// ============================================================
// Module   : tb_avalon_aes_interface
// Purpose  : scoreboard bench for avalon_aes_interface
// Revision : 1.0
// ============================================================
module tb_avalon_aes_interface;

  localparam logic [2:0] P_START  = 3'd0;
  localparam logic [2:0] P_EXPORT = 3'd1;
  localparam logic [2:0] P_KEY    = 3'd2;
  localparam logic [2:0] P_ENC    = 3'd3;
  localparam logic [2:0] P_RDATA  = 3'd4;

  typedef struct {
    string        name;
    logic [2:0]   sel;
    logic [127:0] val;
  } exp_t;

  logic clk;
  logic rst;
  logic probe;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t rd_q[$];
  exp_t pr_q[$];

  avalon_aes_interface_if bus ();

  avalon_aes_interface dut (
    .CLK   (clk),
    .RESET (rst),
    .avl   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic compare(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Monitor: reads are checked whenever the bus presents one, probes whenever flagged.
  always @(negedge clk) begin : monitor
    exp_t         e;
    logic [127:0] act;
    if (bus.AVL_CS && bus.AVL_READ) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_read: got %h, expected no read", bus.AVL_READDATA);
      end else begin
        e = rd_q.pop_front();
        compare(e.name, {96'b0, bus.AVL_READDATA}, e.val);
      end
    end
    if (probe) begin
      if (pr_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_probe: got probe, expected none");
      end else begin
        e = pr_q.pop_front();
        case (e.sel)
          P_START:  act = {127'b0, bus.AES_START};
          P_EXPORT: act = {96'b0, bus.EXPORT_DATA};
          P_KEY:    act = bus.AES_KEY;
          P_ENC:    act = bus.AES_MSG_ENC;
          default:  act = {96'b0, bus.AVL_READDATA};
        endcase
        compare(e.name, act, e.val);
      end
    end
  end

  task automatic bus_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] be, input logic cs);
    bus.AVL_CS        = cs;
    bus.AVL_WRITE     = 1'b1;
    bus.AVL_ADDR      = addr;
    bus.AVL_WRITEDATA = data;
    bus.AVL_BYTE_EN   = be;
    @(posedge clk); #1;
    bus.AVL_CS        = 1'b0;
    bus.AVL_WRITE     = 1'b0;
    bus.AVL_WRITEDATA = 32'h0;
    bus.AVL_BYTE_EN   = 4'h0;
  endtask

  task automatic exp_read(input logic [3:0] addr, input logic [31:0] val, input string name);
    exp_t e;
    e.name = name; e.sel = P_RDATA; e.val = {96'b0, val};
    rd_q.push_back(e);
    bus.AVL_CS   = 1'b1;
    bus.AVL_READ = 1'b1;
    bus.AVL_ADDR = addr;
    @(posedge clk); #1;
    bus.AVL_CS   = 1'b0;
    bus.AVL_READ = 1'b0;
  endtask

  task automatic exp_probe(input logic [2:0] sel, input logic [127:0] val, input string name);
    exp_t e;
    e.name = name; e.sel = sel; e.val = val;
    pr_q.push_back(e);
    probe = 1'b1;
    @(posedge clk); #1;
    probe = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    rst = 1'b1;
    probe = 1'b0;
    bus.AVL_READ = 1'b0; bus.AVL_WRITE = 1'b0; bus.AVL_CS = 1'b0;
    bus.AVL_BYTE_EN = 4'h0; bus.AVL_ADDR = 4'h0; bus.AVL_WRITEDATA = 32'h0;
    bus.AES_DONE = 1'b0; bus.AES_MSG_DEC = 128'h0;
    repeat (3) @(posedge clk); #1;
    rst = 1'b0;

    // Reset state
    exp_probe(P_START, 128'h0, "start_rst");
    exp_probe(P_EXPORT, 128'h0, "export_rst");
    exp_probe(P_KEY, 128'h0, "key_rst");
    exp_probe(P_ENC, 128'h0, "enc_rst");
    exp_probe(P_RDATA, 128'h0, "rdata_idle");
    for (int i = 0; i < 16; i++) exp_read(4'(i), 32'h0, "rd_rst");

    // Key and export
    bus_write(4'd0, 32'hDEADBEEF, 4'hF, 1'b1);
    bus_write(4'd3, 32'h01234567, 4'hF, 1'b1);
    exp_probe(P_KEY, {32'hDEADBEEF, 64'h0, 32'h01234567}, "key_words");
    exp_probe(P_EXPORT, {96'b0, 32'hDEAD4567}, "export");
    exp_read(4'd0, 32'hDEADBEEF, "rd_key0");

    // Byte enables and chip select gating
    bus_write(4'd4, 32'hAABBCCDD, 4'h5, 1'b1);
    exp_read(4'd4, 32'h00BB00DD, "be_0101");
    bus_write(4'd5, 32'h11223344, 4'hF, 1'b1);
    bus_write(4'd7, 32'hCAFEF00D, 4'hA, 1'b1);
    exp_read(4'd7, 32'hCA00F000, "be_1010");
    exp_probe(P_ENC, {32'h00BB00DD, 32'h11223344, 32'h0, 32'hCA00F000}, "msg_enc");
    bus_write(4'd1, 32'hFFFFFFFF, 4'hF, 1'b0);
    exp_read(4'd1, 32'h0, "write_no_cs");
    bus.AVL_READ = 1'b1; bus.AVL_ADDR = 4'd0;
    exp_probe(P_RDATA, 128'h0, "read_no_cs");
    bus.AVL_READ = 1'b0;

    // START with byte 0 disabled does nothing
    bus_write(4'd14, 32'h1, 4'h2, 1'b1);
    exp_probe(P_START, 128'h0, "start_be0_off");

    // Full handshake
    bus_write(4'd14, 32'h1, 4'h1, 1'b1);
    exp_probe(P_START, 128'h1, "start_run");
    exp_read(4'd15, 32'h0, "done_in_run");
    bus.AES_MSG_DEC = 128'h00112233_44556677_8899AABB_CCDDEEFF;
    bus.AES_DONE = 1'b1;
    @(posedge clk); #1;
    exp_read(4'd8,  32'h00112233, "dec0");
    exp_read(4'd9,  32'h44556677, "dec1");
    exp_read(4'd10, 32'h8899AABB, "dec2");
    exp_read(4'd11, 32'hCCDDEEFF, "dec3");
    exp_read(4'd15, 32'h1, "done_set");
    exp_probe(P_START, 128'h1, "start_in_done");
    bus_write(4'd14, 32'h1, 4'h1, 1'b1);
    exp_read(4'd15, 32'h1, "done_restart");
    bus_write(4'd9, 32'hFFFFFFFF, 4'hF, 1'b1);
    bus_write(4'd15, 32'hFFFFFFFF, 4'hF, 1'b1);
    exp_read(4'd9, 32'h44556677, "dec_ro");
    exp_read(4'd15, 32'h1, "done_ro");
    bus_write(4'd14, 32'h0, 4'h1, 1'b1);
    exp_read(4'd15, 32'h0, "done_clr");
    exp_probe(P_START, 128'h0, "start_idle");

    // AES_DONE held in IDLE with new data is ignored
    bus.AES_MSG_DEC = '1;
    exp_read(4'd8, 32'h00112233, "idle_no_cap");
    exp_read(4'd15, 32'h0, "idle_done_ign");
    bus.AES_DONE = 1'b0;

    // Abort before completion
    bus_write(4'd14, 32'h1, 4'h1, 1'b1);
    exp_probe(P_START, 128'h1, "start_abort_run");
    bus_write(4'd14, 32'h0, 4'h1, 1'b1);
    exp_probe(P_START, 128'h0, "start_abort");
    exp_read(4'd8, 32'h00112233, "abort_dec0");
    exp_read(4'd11, 32'hCCDDEEFF, "abort_dec3");
    exp_read(4'd15, 32'h0, "abort_done");

`ifdef AES_CYCLE_COUNT_EN
    bus_write(4'd14, 32'h1, 4'h1, 1'b1);
    repeat (37) @(posedge clk);
    #1;
    bus.AES_DONE = 1'b1;
    @(posedge clk); #1;
    exp_read(4'd12, 32'd37, "cnt_run");
    repeat (5) @(posedge clk);
    #1;
    exp_read(4'd12, 32'd37, "cnt_frozen");
    bus_write(4'd14, 32'h0, 4'h1, 1'b1);
    bus.AES_DONE = 1'b0;
`else
    exp_read(4'd12, 32'h0, "cnt_absent");
    exp_read(4'd13, 32'h0, "reg13_zero");
`endif

    // Asynchronous reset mid-RUN
    bus_write(4'd14, 32'h1, 4'h1, 1'b1);
    exp_probe(P_START, 128'h1, "start_pre_rst");
    exp_probe(P_EXPORT, {96'b0, 32'hDEAD4567}, "export_pre_rst");
    #2;
    rst = 1'b1;
    exp_probe(P_START, 128'h0, "start_async_rst");
    exp_probe(P_EXPORT, 128'h0, "export_async_rst");
    rst = 1'b0;
    for (int i = 0; i < 16; i++) exp_read(4'(i), 32'h0, "rd_post_rst");
    exp_probe(P_KEY, 128'h0, "key_post_rst");

    @(posedge clk); #1;
    if (rd_q.size() != 0 || pr_q.size() != 0) begin
      n_checks++;
      $display("FAIL leftover: got %0d pending, expected 0", rd_q.size() + pr_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/avalon_aes_interface.md
Name: avalon_aes_interface

Overview:
- Avalon-MM slave register file between the Nios II bus and the AES decryption core; this is the component that drives the SoC's 32-bit AES export conduit.
- Software writes the key and the encrypted message, then sets START.
- The block presents these values to the core, captures the decrypted message when the core reports done, and exposes status.
- EXPORT_DATA drives the board hex displays with key bits [127:112] and [15:0].

Parameters:
- NUM_REGS, 16, number of 32-bit registers; address width is log2(NUM_REGS)=4.
- START_IDX, 14, register index of the START control register.
- DONE_IDX, 15, register index of the DONE status register.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- AVL_READ  in  1  Avalon read strobe.
- AVL_WRITE  in  1  Avalon write strobe.
- AVL_CS  in  1  chip select; read and write are ignored unless CS=1.
- AVL_BYTE_EN  in  4  write byte enables; bit i enables WRITEDATA[8i+7:8i].
- AVL_ADDR  in  4  register index.
- AVL_WRITEDATA  in  32  write data.
- AVL_READDATA  out  32  read data.
- EXPORT_DATA  out  32  {key[127:112], key[15:0]} to the hex display.
- AES_START  out  1  level request to the decryption core.
- AES_KEY  out  128  {reg0,reg1,reg2,reg3}; reg0 holds [127:96].
- AES_MSG_ENC  out  128  {reg4..reg7}, same word ordering.
- AES_DONE  in  1  core completion; a level held until START drops.
- AES_MSG_DEC  in  128  decrypted message; valid while AES_DONE=1.

Behaviour:
- Reset:
  - Single clock CLK. Reset is asynchronous and active-high on RESET.
  - All registers clear to 0, so AES_START=0, AES_KEY=0, AES_MSG_ENC=0 and EXPORT_DATA=0.
  - AVL_READDATA=0 while no read is active.
- Reads:
  - Zero wait states; combinational.
  - AVL_READDATA = reg[AVL_ADDR] when CS&READ, else 0.
  - Unused indices 12–13 read 0 unless AES_CYCLE_COUNT_EN is defined.
- Writes:
  - Take effect on the CLK rising edge when CS&WRITE; only the enabled bytes are updated.
  - Indices 0–7 and START_IDX are software-writable.
  - Indices 8–11 (MSG_DEC) and DONE_IDX are read-only; writes to them are dropped.
- Handshake state machine, states IDLE, RUN, DONE:
  - IDLE: AES_START=0, done register=0. A write of bit0=1 to START (byte0 enabled) goes to RUN next cycle, with AES_START=1.
  - RUN: AES_START=1. When AES_DONE=1, latch AES_MSG_DEC into reg8..reg11 (reg8=[127:96]), set DONE bit0=1, and go to DONE. Capture happens on the same edge that AES_DONE is sampled high.
  - DONE: AES_START stays 1 and the captured message stays stable. A write of bit0=0 to START returns to IDLE and clears DONE on the same edge.
- Boundary cases:
  - START written to 0 while in RUN: abort to IDLE. AES_START drops next cycle and reg8–11 are unchanged.
  - AES_DONE high in IDLE: ignored.
  - START rewritten to 1 in RUN or DONE: no effect.
  - A write to key or message registers during RUN/DONE is accepted. The core must not rely on it; software avoids it.
  - RESET mid-RUN: immediate IDLE, all registers 0.
- EXPORT_DATA tracks reg0[31:16] and reg3[15:0] with no latency beyond the register itself.

Optional Feature:
- Macro AES_CYCLE_COUNT_EN.
- Defined:
  - Register 12 is a 32-bit read-only cycle counter. It clears on the IDLE→RUN transition and increments each cycle in RUN.
  - It freezes in DONE and on abort, saturates at 0xFFFFFFFF, and resets to 0.
- Undefined: register 12 reads 0 and no counter logic is built.

Decomposition:
- Package aes_if_pkg holds:
  - register index constants: KEY0=0, ENC0=4, DEC0=8, CNT=12, START=14, DONE=15;
  - the state enum aes_if_state_t {IDLE, RUN, DONE};
  - a byte-enable merge function.
- Sub-module aes_if_regfile (16×32 storage with byte-enable writes and hardware capture port); the handshake FSM stays in the top module.

Test Plan:
- Reset check: assert RESET asynchronously mid-cycle → all reads return 0; EXPORT_DATA=0 and AES_START=0 immediately.
- Key and export: write reg0=0xDEADBEEF and reg3=0x01234567 with BYTE_EN=0xF → AES_KEY[127:96]=0xDEADBEEF, EXPORT_DATA=0xDEAD4567.
- Byte enables: write reg4=0xAABBCCDD with BYTE_EN=0x5 over an initial 0 → reg4 reads 0x00BB00DD.
- Full handshake:
  - Write START=1 → AES_START=1 next cycle.
  - Drive AES_MSG_DEC=0x00112233_44556677_8899AABB_CCDDEEFF with AES_DONE=1 → reg8=0x00112233, reg11=0xCCDDEEFF, DONE reads 1.
  - Write START=0 → DONE reads 0.
- Read-only and abort:
  - Write 0xFFFFFFFF to reg9 and DONE → both unchanged.
  - START=1 then START=0 before AES_DONE → IDLE; reg8–11 unchanged.
- With AES_CYCLE_COUNT_EN: hold AES_DONE low 37 cycles after START → reg12 reads 37, then stays frozen after DONE.
